mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage that sits directly upstream of the write-back mux and drives its registered source inputs: pc_result, alu_result, bshift_result, data_result and source_select.
- Performs load/store accesses to data memory over a req/ack handshake, aligns and sign-extends load data, and generates byte enables for stores.
- Stalls the pipeline while an access is outstanding and terminates hung accesses with a timeout.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait in WAIT for dmem_ack before aborting; must be 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  EX/MEM entry valid.
- in_ready  output  1  stage accepts an entry this cycle; upstream holds in_* while low.
- in_mem_read  input  1  load.
- in_mem_write  input  1  store; never asserted together with in_mem_read.
- in_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_alu_result  input  32  ALU result and effective address.
- in_bshift_result  input  32  barrel-shifter result.
- in_pc_result  input  32  link value (PC+4).
- in_store_data  input  32  rs2 value.
- in_source_select  input  2  write-back source: 0 ALU, 1 BShift, 2 PC, 3 D_Mem.
- in_rd  input  5  destination register.
- in_reg_write  input  1  register write enable.
- dmem_req  output  1  access request.
- dmem_we  output  1  store when 1.
- dmem_addr  output  32  word address, bits [1:0] forced to 0.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_rdata  input  32  load data, valid when dmem_ack is high.
- dmem_ack  input  1  access complete.
- wb_valid  output  1  MEM/WB entry valid.
- wb_alu_result, wb_bshift_result, wb_pc_result, wb_data_result  output  32 each  registered results.
- wb_source_select  output  2  registered write-back source.
- wb_rd  output  5  registered destination register.
- wb_reg_write  output  1  registered write enable, qualified by wb_valid.
- misalign  output  1  one-cycle pulse for a misaligned access.
- bus_error  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state IDLE, all wb_* = 0, dmem_req = 0, dmem_we = 0, dmem_addr/wdata/be = 0, misalign = 0, bus_error = 0, timeout counter = 0. Reset mid-access drops dmem_req on the next edge; a late dmem_ack is ignored.
- in_ready = (state == IDLE).
- States:
  - IDLE: accepts in_valid.
    - Non-memory op: registers into wb_* on the next edge; wb_data_result = 0; latency 1.
    - Aligned memory op: latches address, size and fields; goes to WAIT. dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are registered and valid from the first WAIT cycle.
    - Misaligned memory op (H/HU with addr[0]=1; W with addr[1:0]!=0): no memory access; stays in IDLE; next edge gives wb_valid=1, wb_reg_write=0, misalign=1.
  - WAIT: dmem_req held with all dmem_* stable.
    - dmem_ack sampled high: next edge drops dmem_req, returns to IDLE, wb_valid=1, wb_data_result = formatted load (0 for stores).
    - Ack in the first WAIT cycle gives 2-cycle latency from acceptance.
    - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES: drop req, return to IDLE, wb_valid=1, wb_reg_write=0, bus_error=1. If ack arrives in the same cycle as the timeout, ack wins.
- wb_valid is low in every cycle no entry completes, including every WAIT cycle without ack. wb_* hold their last values when wb_valid is low.
- Load formatting, lane = addr[1:0]:
  - B/BU select byte lane; H/HU select half lane addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Stores:
  - B: be = 0001 << lane, wdata = byte replicated x4.
  - H: be = 0011 << (2*addr[1]), wdata = half replicated x2.
  - W: be = 1111.
- Loads: be = 1111, wdata = 0.
- Undefined funct3 on a memory op: treated as W.

Test Plan:
- Reset then in_valid with ALU op, alu_result=0x1234, rd=5 -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, dmem_req never asserted.
- LB at addr 0x103, dmem_rdata=0x80FF_0000, ack in the 3rd WAIT cycle -> dmem_addr=0x100, in_ready low 3 cycles, wb_data_result=0xFFFF_FF80; with LBU -> 0x0000_0080.
- SH at 0x102, store_data=0xDEAD_BEEF, immediate ack -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, wb_valid 2 cycles after acceptance.
- LW at 0x101 -> no dmem_req, misalign=1 and wb_valid=1 with wb_reg_write=0 on the next cycle, in_ready stays high.
- LW with no ack, TIMEOUT_CYCLES=4 -> dmem_req high exactly 4 cycles, then bus_error=1, wb_reg_write=0; ack coinciding with the 4th cycle -> normal completion, no bus_error.
- rst asserted during WAIT, then ack arrives -> dmem_req=0 and all wb_* = 0 after the edge; ack ignored, no wb_valid.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Bundle of the EX/MEM input entry, the data-memory req/ack bus and the MEM/WB result registers.
// No logic. The stage drives the outputs combinationally or from registers.
// master = the stage's view; slave = the environment (upstream, memory, write-back).
// Signal groups: in_* (entry from EX), dmem_* (memory access), wb_* (results to the write-back mux),
// and misalign/bus_error (status pulses).
interface mem_access_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_bshift_result;
    logic [31:0] in_pc_result;
    logic [31:0] in_store_data;
    logic [1:0]  in_source_select;
    logic [4:0]  in_rd;
    logic        in_reg_write;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_bshift_result;
    logic [31:0] wb_pc_result;
    logic [31:0] wb_data_result;
    logic [1:0]  wb_source_select;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;
    logic        bus_error;

    modport master (
        input  in_valid, in_mem_read, in_mem_write, in_funct3, in_alu_result,
               in_bshift_result, in_pc_result, in_store_data, in_source_select,
               in_rd, in_reg_write, dmem_rdata, dmem_ack,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               wb_valid, wb_alu_result, wb_bshift_result, wb_pc_result,
               wb_data_result, wb_source_select, wb_rd, wb_reg_write,
               misalign, bus_error
    );

    modport slave (
        output in_valid, in_mem_read, in_mem_write, in_funct3, in_alu_result,
               in_bshift_result, in_pc_result, in_store_data, in_source_select,
               in_rd, in_reg_write, dmem_rdata, dmem_ack,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               wb_valid, wb_alu_result, wb_bshift_result, wb_pc_result,
               wb_data_result, wb_source_select, wb_rd, wb_reg_write,
               misalign, bus_error
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: load/store over req/ack, load alignment/extension, store byte enables.
// Latency: 1 cycle for non-memory and misaligned ops, 2+ cycles for memory ops (1 + WAIT cycles).
// Backpressure: in_ready low while an access is outstanding; hung accesses abort after TIMEOUT_CYCLES.
// Ports: clk, rst (sync, active-high), bus (mem_access_stage_if.master: in_*, dmem_*, wb_*, misalign, bus_error).
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16   // 1..255
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_stage_if.master    bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt;

    logic        in_ready_c, dmem_req_c, done_ok, done_tmo;

    // entry fields held across the access
    logic [31:0] lat_alu, lat_bshift, lat_pc;
    logic [1:0]  lat_src;
    logic [4:0]  lat_rd;
    logic        lat_rw;
    logic [1:0]  lat_lane;
    logic        lat_sz_b, lat_sz_h, lat_uns;

    // registered outputs
    logic        dmem_we_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_be_q;
    logic        wb_valid_q, wb_rw_q, misalign_q, bus_error_q;
    logic [31:0] wb_alu_q, wb_bshift_q, wb_pc_q, wb_data_q;
    logic [1:0]  wb_src_q;
    logic [4:0]  wb_rd_q;

    // request decode
    logic        is_mem, sz_b, sz_h, addr_mis;
    logic        acc_mem, acc_mis, acc_alu;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // funct3[1:0] picks the size: 00 byte, 01 half, anything else (incl. undefined codes) word.
    always_comb begin
        is_mem   = bus.in_mem_read | bus.in_mem_write;
        sz_b     = (bus.in_funct3[1:0] == 2'b00);
        sz_h     = (bus.in_funct3[1:0] == 2'b01);
        addr_mis = sz_h ? bus.in_alu_result[0]
                        : (!sz_b && (bus.in_alu_result[1:0] != 2'b00));
        acc_alu  = in_ready_c && bus.in_valid && !is_mem;
        acc_mis  = in_ready_c && bus.in_valid &&  is_mem &&  addr_mis;
        acc_mem  = in_ready_c && bus.in_valid &&  is_mem && !addr_mis;
    end

    // store lane enables and replicated data; loads read the whole word
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (bus.in_mem_write) begin
            if (sz_b) begin
                case (bus.in_alu_result[1:0])
                    2'd0:    st_be = 4'b0001;
                    2'd1:    st_be = 4'b0010;
                    2'd2:    st_be = 4'b0100;
                    default: st_be = 4'b1000;
                endcase
                st_wdata = {4{bus.in_store_data[7:0]}};
            end else if (sz_h) begin
                st_be    = bus.in_alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.in_store_data[15:0]}};
            end else begin
                st_wdata = bus.in_store_data;
            end
        end
    end

    // load formatting from the lane captured at acceptance
    always_comb begin
        case (lat_lane)
            2'd0:    ld_byte = bus.dmem_rdata[7:0];
            2'd1:    ld_byte = bus.dmem_rdata[15:8];
            2'd2:    ld_byte = bus.dmem_rdata[23:16];
            default: ld_byte = bus.dmem_rdata[31:24];
        endcase
        ld_half = lat_lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        if (lat_sz_b)
            ld_fmt = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
        else if (lat_sz_h)
            ld_fmt = {{16{~lat_uns & ld_half[15]}}, ld_half};
        else
            ld_fmt = bus.dmem_rdata;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc_mem) state_nxt = S_WAIT;
            S_WAIT:  if (done_ok || done_tmo) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. Ack beats a timeout landing in the same cycle.
    always_comb begin
        in_ready_c = (state == S_IDLE);
        dmem_req_c = (state == S_WAIT);
        done_ok    = (state == S_WAIT) &&  bus.dmem_ack;
        done_tmo   = (state == S_WAIT) && !bus.dmem_ack && (tmo_cnt == TMO_LAST);
    end

    // counts completed WAIT cycles without ack; zero whenever not waiting
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= 8'd0;
        else if ((state == S_WAIT) && !bus.dmem_ack && !done_tmo)
            tmo_cnt <= tmo_cnt + 8'd1;
        else
            tmo_cnt <= 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_alu      <= '0;  lat_bshift <= '0;  lat_pc   <= '0;
            lat_src      <= '0;  lat_rd     <= '0;  lat_rw   <= 1'b0;
            lat_lane     <= '0;  lat_sz_b   <= 1'b0; lat_sz_h <= 1'b0; lat_uns <= 1'b0;
            dmem_we_q    <= 1'b0; dmem_addr_q <= '0; dmem_wdata_q <= '0; dmem_be_q <= '0;
            wb_valid_q   <= 1'b0; wb_rw_q     <= 1'b0;
            misalign_q   <= 1'b0; bus_error_q <= 1'b0;
            wb_alu_q     <= '0;  wb_bshift_q <= '0; wb_pc_q <= '0; wb_data_q <= '0;
            wb_src_q     <= '0;  wb_rd_q     <= '0;
        end else begin
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_error_q <= 1'b0;

            // single-cycle completions straight from the inputs
            if (acc_alu || acc_mis) begin
                wb_valid_q  <= 1'b1;
                wb_alu_q    <= bus.in_alu_result;
                wb_bshift_q <= bus.in_bshift_result;
                wb_pc_q     <= bus.in_pc_result;
                wb_src_q    <= bus.in_source_select;
                wb_rd_q     <= bus.in_rd;
                wb_data_q   <= 32'h0;
                wb_rw_q     <= acc_alu & bus.in_reg_write;
                misalign_q  <= acc_mis;
            end

            if (acc_mem) begin
                lat_alu      <= bus.in_alu_result;
                lat_bshift   <= bus.in_bshift_result;
                lat_pc       <= bus.in_pc_result;
                lat_src      <= bus.in_source_select;
                lat_rd       <= bus.in_rd;
                lat_rw       <= bus.in_reg_write;
                lat_lane     <= bus.in_alu_result[1:0];
                lat_sz_b     <= sz_b;
                lat_sz_h     <= sz_h;
                lat_uns      <= bus.in_funct3[2];
                dmem_we_q    <= bus.in_mem_write;
                dmem_addr_q  <= {bus.in_alu_result[31:2], 2'b00};
                dmem_wdata_q <= st_wdata;
                dmem_be_q    <= st_be;
            end

            if (done_ok || done_tmo) begin
                wb_valid_q  <= 1'b1;
                wb_alu_q    <= lat_alu;
                wb_bshift_q <= lat_bshift;
                wb_pc_q     <= lat_pc;
                wb_src_q    <= lat_src;
                wb_rd_q     <= lat_rd;
                wb_data_q   <= (done_ok && !dmem_we_q) ? ld_fmt : 32'h0;
                wb_rw_q     <= done_ok & lat_rw;
                bus_error_q <= done_tmo;
            end
        end
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.dmem_req         = dmem_req_c;
    assign bus.dmem_we          = dmem_we_q;
    assign bus.dmem_addr        = dmem_addr_q;
    assign bus.dmem_wdata       = dmem_wdata_q;
    assign bus.dmem_be          = dmem_be_q;
    assign bus.wb_valid         = wb_valid_q;
    assign bus.wb_alu_result    = wb_alu_q;
    assign bus.wb_bshift_result = wb_bshift_q;
    assign bus.wb_pc_result     = wb_pc_q;
    assign bus.wb_data_result   = wb_data_q;
    assign bus.wb_source_select = wb_src_q;
    assign bus.wb_rd            = wb_rd_q;
    // write enable only means something alongside wb_valid
    assign bus.wb_reg_write     = wb_rw_q & wb_valid_q;
    assign bus.misalign         = misalign_q;
    assign bus.bus_error        = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_at;   // WAIT cycle (1-based) carrying ack; 0 = never
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
        end
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int     n;
        longint v, span;
        n = m_size(f3);
        if (n == 4) return rdata;
        span = longint'(1) << (8 * n);
        v = longint'(rdata >> (8 * (addr % 4))) % span;
        if (f3 < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = m_size(f3);
        if (!st) return 4'hF;
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic st, input logic [2:0] f3, input logic [31:0] sd);
        int     n;
        longint w, piece;
        if (!st) return 32'h0;
        n = m_size(f3);
        if (n == 4) return sd;
        piece = longint'(sd) % (longint'(1) << (8 * n));
        w = 0;
        for (int c = 0; c < 4 / n; c++) w = w + (piece << (8 * n * c));
        return 32'(w);
    endfunction

    function automatic vec_t vec(input logic ld, st, input logic [2:0] f3, input logic [31:0] addr, sd, rdata,
                                 input int ack_at, input logic [3:0] be, input logic [31:0] wdata, data, input logic mis);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
        v.ack_at = ack_at; v.be = be; v.wdata = wdata; v.data = data; v.mis = mis;
        return v;
    endfunction

    // One entry through the stage, checked cycle by cycle until it retires.
    task automatic txn(input string tag, input logic ld, st, input logic [2:0] f3,
                       input logic [31:0] addr, sd, rdat, input int ack_at,
                       input logic [1:0] src, input logic [4:0] rd, input logic rw,
                       input logic [31:0] pc, bsh,
                       input logic [3:0] e_be, input logic [31:0] e_wdata, e_data, input logic e_mis);
        logic mem, tmo;
        int   last;
        mem  = ld | st;
        tmo  = mem && !e_mis && (ack_at == 0 || ack_at > T);
        last = tmo ? T : ack_at;

        bus.in_valid         = 1'b1;
        bus.in_mem_read      = ld;
        bus.in_mem_write     = st;
        bus.in_funct3        = f3;
        bus.in_alu_result    = addr;
        bus.in_bshift_result = bsh;
        bus.in_pc_result     = pc;
        bus.in_store_data    = sd;
        bus.in_source_select = src;
        bus.in_rd            = rd;
        bus.in_reg_write     = rw;
        bus.dmem_ack         = 1'b0;
        chk(tag, "in_ready at accept", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_alu_result = $urandom;

        if (mem && !e_mis) begin
            for (int k = 1; k <= last; k++) begin
                chk(tag, "dmem_req in WAIT", 32'(bus.dmem_req), 32'd1);
                chk(tag, "in_ready in WAIT", 32'(bus.in_ready), 32'd0);
                chk(tag, "wb_valid in WAIT", 32'(bus.wb_valid), 32'd0);
                if (k == 1) begin
                    chk(tag, "dmem_addr", bus.dmem_addr, addr - (addr % 4));
                    chk(tag, "dmem_be", 32'(bus.dmem_be), 32'(e_be));
                    chk(tag, "dmem_wdata", bus.dmem_wdata, e_wdata);
                    chk(tag, "dmem_we", 32'(bus.dmem_we), 32'(st));
                end
                bus.dmem_ack   = (k == ack_at);
                bus.dmem_rdata = (k == ack_at) ? rdat : $urandom;
                step();
                bus.dmem_ack = 1'b0;
            end
        end

        chk(tag, "wb_valid", 32'(bus.wb_valid), 32'd1);
        chk(tag, "wb_reg_write", 32'(bus.wb_reg_write), 32'(rw && !e_mis && !tmo));
        chk(tag, "wb_data_result", bus.wb_data_result, e_data);
        chk(tag, "misalign", 32'(bus.misalign), 32'(e_mis));
        chk(tag, "bus_error", 32'(bus.bus_error), 32'(tmo));
        chk(tag, "dmem_req after", 32'(bus.dmem_req), 32'd0);
        chk(tag, "in_ready after", 32'(bus.in_ready), 32'd1);
        chk(tag, "wb_alu_result", bus.wb_alu_result, addr);
        chk(tag, "wb_bshift_result", bus.wb_bshift_result, bsh);
        chk(tag, "wb_pc_result", bus.wb_pc_result, pc);
        chk(tag, "wb_source_select", 32'(bus.wb_source_select), 32'(src));
        chk(tag, "wb_rd", 32'(bus.wb_rd), 32'(rd));
        step();
        chk(tag, "wb_valid pulse", 32'(bus.wb_valid), 32'd0);
        chk(tag, "misalign pulse", 32'(bus.misalign), 32'd0);
        chk(tag, "bus_error pulse", 32'(bus.bus_error), 32'd0);
        chk(tag, "wb_reg_write idle", 32'(bus.wb_reg_write), 32'd0);
        chk(tag, "wb_alu_result hold", bus.wb_alu_result, addr);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.in_valid         = 1'b0;
        bus.in_mem_read      = 1'b0;
        bus.in_mem_write     = 1'b0;
        bus.in_funct3        = 3'd0;
        bus.in_alu_result    = 32'h0;
        bus.in_bshift_result = 32'h0;
        bus.in_pc_result     = 32'h0;
        bus.in_store_data    = 32'h0;
        bus.in_source_select = 2'd0;
        bus.in_rd            = 5'd0;
        bus.in_reg_write     = 1'b0;
        bus.dmem_rdata       = 32'h0;
        bus.dmem_ack         = 1'b0;

        //         ld st f3    addr          sd            rdata         ack be     wdata         data          mis
        tbl.push_back(vec(0, 0, 3'd0, 32'h0000_1234, 32'h0,        32'h0,        1, 4'hF, 32'h0,        32'h0,        0));
        tbl.push_back(vec(1, 0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 3, 4'hF, 32'h0,        32'hFFFF_FF80, 0));
        tbl.push_back(vec(1, 0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_0000, 3, 4'hF, 32'h0,        32'h0000_0080, 0));
        tbl.push_back(vec(0, 1, 3'd1, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,       1, 4'hC, 32'hBEEF_BEEF, 32'h0,        0));
        tbl.push_back(vec(1, 0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        1, 4'hF, 32'h0,        32'h0,        1));
        tbl.push_back(vec(1, 0, 3'd1, 32'h0000_0102, 32'h0,        32'h9234_0001, 1, 4'hF, 32'h0,        32'hFFFF_9234, 0));
        tbl.push_back(vec(1, 0, 3'd5, 32'h0000_0100, 32'h0,        32'h0000_F00D, 2, 4'hF, 32'h0,        32'h0000_F00D, 0));
        tbl.push_back(vec(0, 1, 3'd0, 32'h0000_0101, 32'h0000_00A5, 32'h0,       1, 4'h2, 32'hA5A5_A5A5, 32'h0,        0));
        tbl.push_back(vec(0, 1, 3'd0, 32'h0000_0103, 32'h1234_5678, 32'h0,       2, 4'h8, 32'h7878_7878, 32'h0,        0));
        tbl.push_back(vec(0, 1, 3'd2, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,       1, 4'hF, 32'hCAFE_F00D, 32'h0,        0));
        tbl.push_back(vec(1, 0, 3'd2, 32'h0000_0204, 32'h0,        32'h89AB_CDEF, 1, 4'hF, 32'h0,        32'h89AB_CDEF, 0));
        tbl.push_back(vec(1, 0, 3'd1, 32'h0000_0103, 32'h0,        32'h0,        1, 4'hF, 32'h0,        32'h0,        1));
        tbl.push_back(vec(0, 1, 3'd1, 32'h0000_0101, 32'h5555_AAAA, 32'h0,       1, 4'hF, 32'h0,        32'h0,        1));
        tbl.push_back(vec(1, 0, 3'd3, 32'h0000_0102, 32'h0,        32'h0,        1, 4'hF, 32'h0,        32'h0,        1));
        tbl.push_back(vec(1, 0, 3'd3, 32'h0000_0108, 32'h0,        32'h1122_3344, 1, 4'hF, 32'h0,        32'h1122_3344, 0));
        tbl.push_back(vec(1, 0, 3'd0, 32'h0000_0100, 32'h0,        32'h0000_007F, 1, 4'hF, 32'h0,        32'h0000_007F, 0));
        tbl.push_back(vec(1, 0, 3'd0, 32'h0000_0102, 32'h0,        32'h0080_0000, 1, 4'hF, 32'h0,        32'hFFFF_FF80, 0));
        tbl.push_back(vec(1, 0, 3'd2, 32'h0000_0300, 32'h0,        32'h5A5A_5A5A, 0, 4'hF, 32'h0,        32'h0,        0));
        tbl.push_back(vec(1, 0, 3'd2, 32'h0000_0304, 32'h0,        32'h0BAD_CAFE, 4, 4'hF, 32'h0,        32'h0BAD_CAFE, 0));
        tbl.push_back(vec(0, 1, 3'd2, 32'h0000_0308, 32'h1357_9BDF, 32'h0,       5, 4'hF, 32'h1357_9BDF, 32'h0,        0));

        // reset state
        repeat (3) step();
        chk("reset", "wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("reset", "dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("reset", "dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("reset", "dmem_addr", bus.dmem_addr, 32'h0);
        chk("reset", "dmem_wdata", bus.dmem_wdata, 32'h0);
        chk("reset", "dmem_be", 32'(bus.dmem_be), 32'h0);
        chk("reset", "misalign", 32'(bus.misalign), 32'd0);
        chk("reset", "bus_error", 32'(bus.bus_error), 32'd0);
        chk("reset", "wb_alu_result", bus.wb_alu_result, 32'h0);
        chk("reset", "wb_data_result", bus.wb_data_result, 32'h0);
        chk("reset", "wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("reset", "wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        chk("reset", "in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        step();

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            txn($sformatf("vec%0d", i), v.ld, v.st, v.f3, v.addr, v.sd, v.rdata, v.ack_at,
                v.ld ? 2'd3 : (v.st ? 2'd0 : 2'(i % 3)), 5'(i + 5), !v.st,
                32'h1000 + 32'(4 * i), ~v.addr, v.be, v.wdata, v.data, v.mis);
        end

        // reset during WAIT, late ack must be ignored
        bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_mem_write = 1'b0;
        bus.in_funct3 = 3'd2; bus.in_alu_result = 32'h0000_0400; bus.in_rd = 5'd9;
        bus.in_reg_write = 1'b1; bus.in_source_select = 2'd3;
        step();
        bus.in_valid = 1'b0;
        chk("rst_wait", "dmem_req wait1", 32'(bus.dmem_req), 32'd1);
        step();
        chk("rst_wait", "dmem_req wait2", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait", "dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_wait", "wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wait", "wb_alu_result", bus.wb_alu_result, 32'h0);
        chk("rst_wait", "wb_pc_result", bus.wb_pc_result, 32'h0);
        chk("rst_wait", "wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_wait", "wb_source_select", 32'(bus.wb_source_select), 32'd0);
        chk("rst_wait", "in_ready", 32'(bus.in_ready), 32'd1);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        step();
        bus.dmem_ack = 1'b0;
        chk("rst_wait", "late ack wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wait", "late ack data", bus.wb_data_result, 32'h0);
        chk("rst_wait", "late ack bus_error", 32'(bus.bus_error), 32'd0);
        step();
        chk("rst_wait", "idle wb_valid", 32'(bus.wb_valid), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            int          kind, ack_at;
            logic        ld, st, mis;
            logic [2:0]  f3;
            logic [31:0] addr, sd, rdat, data;
            logic [2:0]  st_codes [6];
            st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
            kind   = $urandom_range(0, 2);
            ld     = (kind == 1);
            st     = (kind == 2);
            f3     = st ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            addr   = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr - (addr % 4);
            sd     = $urandom;
            rdat   = $urandom;
            ack_at = $urandom_range(0, 6);
            mis    = (ld || st) && m_mis(f3, addr);
            data   = (ld && !mis && ack_at >= 1 && ack_at <= T) ? m_load(f3, addr, rdat) : 32'h0;
            txn($sformatf("rnd%0d", n), ld, st, f3, addr, sd, rdat, ack_at,
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, m_be(st, f3, addr), m_wdata(st, f3, sd), data, mis);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
